// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester that drives the UART register block:
// FSM encoding, UART register map and STATS bit positions.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_STATS   = 8'h01;
  localparam logic [7:0] ADDR_TX_DATA = 8'h02;
  localparam logic [7:0] ADDR_RX_DATA = 8'h03;
  localparam logic [7:0] ADDR_BAUDIV  = 8'h04;

  localparam int unsigned STATS_TX_BUSY  = 0;
  localparam int unsigned STATS_TX_DONE  = 1;
  localparam int unsigned STATS_RX_BUSY  = 2;
  localparam int unsigned STATS_RX_DONE  = 3;
  localparam int unsigned STATS_RX_ERROR = 4;

endpackage

// File: rtl/apb_uart_master_if.sv
// Command/response stream plus APB bus seen by the requester.
// The master modport is the requester's view; slave is the environment's view.
interface apb_uart_master_if #(
  parameter int unsigned PADDR_WIDTH  = 32,
  parameter int unsigned PWDATA_WIDTH = 32,
  parameter int unsigned PRDATA_WIDTH = 32
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [PADDR_WIDTH-1:0]  cmd_addr;
  logic [PWDATA_WIDTH-1:0] cmd_wdata;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [PRDATA_WIDTH-1:0] rsp_rdata;
  logic                    rsp_err;
  logic                    rsp_timeout;
  logic [PADDR_WIDTH-1:0]  PADDR;
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [PWDATA_WIDTH-1:0] PWDATA;
  logic [PRDATA_WIDTH-1:0] PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_timeout_cnt.sv
// Saturating wait-state counter; expire flags the ACCESS cycle in which the
// count would reach TIMEOUT_CYCLES. TIMEOUT_CYCLES=0 never expires.
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (en && (cnt != LIMIT))  cnt <= cnt + 1'b1;
  end

  assign expire = (TIMEOUT_CYCLES != 0) && en && (cnt == LIMIT - 1'b1);
endmodule

// File: rtl/apb_uart_master.sv
// APB requester: one command at a time through SETUP/ACCESS, response held in
// RESP until consumed. All outputs registered except cmd_ready.
module apb_uart_master
  import apb_pkg::*;
#(
  parameter int unsigned PADDR_WIDTH    = 32,
  parameter int unsigned PWDATA_WIDTH   = 32,
  parameter int unsigned PRDATA_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic               PCLK,
  input logic               PRESETn,
  apb_uart_master_if.master bus
);
  state_t                  state, state_nxt;
  logic                    psel, psel_nxt;
  logic                    penable, penable_nxt;
  logic                    pwrite, pwrite_nxt;
  logic [PADDR_WIDTH-1:0]  paddr, paddr_nxt;
  logic [PWDATA_WIDTH-1:0] pwdata, pwdata_nxt;
  logic                    rsp_valid, rsp_valid_nxt;
  logic [PRDATA_WIDTH-1:0] rsp_rdata, rsp_rdata_nxt;
  logic                    rsp_err, rsp_err_nxt;
  logic                    rsp_timeout, rsp_timeout_nxt;
  logic                    expire;

  apb_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .clr    ((state == IDLE) && bus.cmd_valid),
    .en     ((state == ACCESS) && !bus.PREADY),
    .expire (expire)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      pwrite      <= pwrite_nxt;
      paddr       <= paddr_nxt;
      pwdata      <= pwdata_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
    end
  end

  // Next values are the values for the following state, so APB and response
  // outputs come straight from flops while still changing on state entry.
  always_comb begin
    state_nxt       = state;
    psel_nxt        = psel;
    penable_nxt     = penable;
    pwrite_nxt      = pwrite;
    paddr_nxt       = paddr;
    pwdata_nxt      = pwdata;
    rsp_valid_nxt   = rsp_valid;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    unique case (state)
      IDLE: if (bus.cmd_valid) begin
        state_nxt   = SETUP;
        paddr_nxt   = bus.cmd_addr;
        pwrite_nxt  = bus.cmd_write;
        pwdata_nxt  = bus.cmd_wdata;
        psel_nxt    = 1'b1;
        penable_nxt = 1'b0;
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
      end
      ACCESS: if (bus.PREADY) begin
        state_nxt       = RESP;
        psel_nxt        = 1'b0;
        penable_nxt     = 1'b0;
        rsp_valid_nxt   = 1'b1;
        rsp_rdata_nxt   = pwrite ? '0 : bus.PRDATA;
        rsp_err_nxt     = bus.PSLVERR;
        rsp_timeout_nxt = 1'b0;
      end else if (expire) begin
        state_nxt       = RESP;
        psel_nxt        = 1'b0;
        penable_nxt     = 1'b0;
        rsp_valid_nxt   = 1'b1;
        rsp_rdata_nxt   = '0;
        rsp_err_nxt     = 1'b1;
        rsp_timeout_nxt = 1'b1;
      end
      RESP: if (bus.rsp_ready) begin
        state_nxt     = IDLE;
        rsp_valid_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_rdata   = rsp_rdata;
  assign bus.rsp_err     = rsp_err;
  assign bus.rsp_timeout = rsp_timeout;
  assign bus.PADDR       = paddr;
  assign bus.PSEL        = psel;
  assign bus.PENABLE     = penable;
  assign bus.PWRITE      = pwrite;
  assign bus.PWDATA      = pwdata;
endmodule

// File: tb/tb_apb_uart_master.sv
// Bench for apb_uart_master: directed and random transfers against a
// transaction-level expectation of response fields and ACCESS length.
module tb_apb_uart_master;
  import apb_pkg::*;

  localparam int unsigned TO = 16;

  logic PCLK;
  logic PRESETn;
  int   n_checks;
  int   n_pass;

  apb_uart_master_if #(.PADDR_WIDTH(32), .PWDATA_WIDTH(32), .PRDATA_WIDTH(32)) bus ();

  apb_uart_master #(
    .PADDR_WIDTH   (32),
    .PWDATA_WIDTH  (32),
    .PRDATA_WIDTH  (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Transaction-level expectation: PREADY low for `waits` ACCESS cycles, then high.
  function automatic void model(input logic wr, input int unsigned waits, input logic [31:0] rdata,
                                input logic slverr, output logic [31:0] e_rdata, output logic e_err,
                                output logic e_to, output int unsigned e_acc);
    if (TO != 0 && waits >= TO) begin
      e_rdata = '0; e_err = 1'b1; e_to = 1'b1; e_acc = TO;
    end else begin
      e_rdata = wr ? 32'h0 : rdata; e_err = slverr; e_to = 1'b0; e_acc = waits + 1;
    end
  endfunction

  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int unsigned waits, input logic [31:0] rdata, input logic slverr,
                        input int unsigned bp, input logic pend);
    logic [31:0] e_rdata;
    logic        e_err, e_to, done;
    int unsigned e_acc, acc;
    model(wr, waits, rdata, slverr, e_rdata, e_err, e_to, e_acc);

    @(negedge PCLK);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
    check("cmd_ready_idle", bus.cmd_ready, 1'b1);
    check("psel_idle", bus.PSEL, 1'b0);
    @(negedge PCLK);
    bus.cmd_valid = 1'b0; bus.cmd_addr = $urandom(); bus.cmd_wdata = $urandom();
    bus.cmd_write = $urandom_range(0, 1);
    check("setup_psel_penable", {bus.PSEL, bus.PENABLE}, 2'b10);
    check("setup_paddr", bus.PADDR, addr);
    check("setup_pwrite", bus.PWRITE, wr);
    check("setup_pwdata", bus.PWDATA, wdata);
    check("setup_cmd_ready", bus.cmd_ready, 1'b0);

    acc = 0; done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge PCLK);
      if (bus.rsp_valid) done = 1'b1;
      else begin
        check("access_psel_penable", {bus.PSEL, bus.PENABLE}, 2'b11);
        check("access_paddr", bus.PADDR, addr);
        check("access_pwrite", bus.PWRITE, wr);
        check("access_pwdata", bus.PWDATA, wdata);
        check("access_cmd_ready", bus.cmd_ready, 1'b0);
        bus.PREADY  = (acc == waits);
        bus.PRDATA  = (acc == waits) ? rdata : $urandom();
        bus.PSLVERR = (acc == waits) ? slverr : 1'b0;
        acc++;
      end
    end
    bus.PREADY = 1'b0; bus.PRDATA = $urandom(); bus.PSLVERR = $urandom_range(0, 1);
    check("rsp_seen", done, 1'b1);
    check("access_cycles", acc, e_acc);

    for (int unsigned i = 0; i <= bp; i++) begin
      if (i == bp) begin
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b0;
      end else if (pend) begin
        bus.cmd_valid = 1'b1;
      end
      check("rsp_valid", bus.rsp_valid, 1'b1);
      check("rsp_rdata", bus.rsp_rdata, e_rdata);
      check("rsp_err", bus.rsp_err, e_err);
      check("rsp_timeout", bus.rsp_timeout, e_to);
      check("resp_psel_penable", {bus.PSEL, bus.PENABLE}, 2'b00);
      check("resp_cmd_ready", bus.cmd_ready, 1'b0);
      @(negedge PCLK);
    end
    bus.rsp_ready = 1'b0;
    check("after_rsp_valid", bus.rsp_valid, 1'b0);
    check("after_cmd_ready", bus.cmd_ready, 1'b1);
    check("after_psel", bus.PSEL, 1'b0);
    check("after_paddr_hold", bus.PADDR, addr);
  endtask

  initial begin
    logic [31:0] stats_val;
    n_checks = 0; n_pass = 0;
    PRESETn = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0; bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_psel", bus.PSEL, 1'b0);
    check("rst_penable", bus.PENABLE, 1'b0);
    check("rst_pwrite", bus.PWRITE, 1'b0);
    check("rst_paddr", bus.PADDR, 32'h0);
    check("rst_pwdata", bus.PWDATA, 32'h0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);

    stats_val = '0;
    stats_val[STATS_TX_DONE] = 1'b1;
    stats_val[STATS_RX_DONE] = 1'b1;
    do_txn(1'b1, 32'(ADDR_BAUDIV), 32'h28B, 0,   32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    do_txn(1'b0, 32'(ADDR_STATS),  32'h0,   2,   stats_val,     1'b0, 1, 1'b0);
    do_txn(1'b0, 32'h7,            32'h0,   0,   32'h1234_5678, 1'b1, 0, 1'b0);
    do_txn(1'b0, 32'(ADDR_RX_DATA), 32'h0,  100, 32'h5555_AAAA, 1'b0, 0, 1'b0);
    do_txn(1'b1, 32'(ADDR_TX_DATA), 32'h41, TO - 1, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    do_txn(1'b0, 32'(ADDR_CTRL),   32'h0,   0,   32'h0000_00C3, 1'b0, 5, 1'b1);

    for (int n = 0; n < 40; n++) begin
      int unsigned w;
      w = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 4);
      do_txn($urandom_range(0, 1), $urandom(), $urandom(), w, $urandom(),
             ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 1));
    end

    // Reset while the slave is stalling mid-ACCESS.
    @(negedge PCLK);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h3;
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge PCLK);
    check("pre_reset_access", {bus.PSEL, bus.PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1;
    check("async_rst_psel_penable", {bus.PSEL, bus.PENABLE}, 2'b00);
    check("async_rst_rsp_valid", bus.rsp_valid, 1'b0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      check("post_rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
      check("post_rst_psel", bus.PSEL, 1'b0);
    end
    bus.rsp_ready = 1'b0;
    do_txn(1'b0, 32'(ADDR_STATS), 32'h0, 1, 32'h0000_0010, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/apb_uart_master.md
Name: apb_uart_master

Overview:
APB requester (master) that drives the UART register block from a simple command/response stream, e.g. a test sequencer or a small CPU-side bridge. It accepts one command at a time on a valid/ready interface. It runs a compliant two-phase APB transfer (SETUP, then ACCESS with wait states) and returns read data, slave error and timeout status on a valid/ready response channel. A wait-state timeout prevents a hung slave from stalling the requester.

Parameters:
PADDR_WIDTH, 32, APB address width
PWDATA_WIDTH, 32, APB write data width
PRDATA_WIDTH, 32, APB read data width
TIMEOUT_CYCLES, 16, max ACCESS cycles without PREADY before abort; 0 disables the timeout

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  PADDR_WIDTH  target address
cmd_wdata  in  PWDATA_WIDTH  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  PRDATA_WIDTH  read data (0 for writes and timeouts)
rsp_err  out  1  PSLVERR seen or timeout
rsp_timeout  out  1  transfer aborted by timeout
PADDR  out  PADDR_WIDTH  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  PWDATA_WIDTH  APB write data
PRDATA  in  PRDATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Single clock PCLK; reset asynchronous, active-low (PRESETn). All outputs are registered except cmd_ready, which is decoded from state.
- Reset values: state=IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0; rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0; timeout counter=0. cmd_ready=1 once reset is released (IDLE).
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA and go to SETUP. Otherwise stay.
- SETUP: exactly one cycle with PSEL=1, PENABLE=0. Then go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA stay stable. The counter increments each ACCESS cycle in which PREADY=0.
- ACCESS exit on PREADY=1:
  - rsp_rdata = PRDATA if read, 0 if write.
  - rsp_err = PSLVERR; rsp_timeout = 0.
  - PSEL and PENABLE drop to 0; go to RESP.
- ACCESS exit on timeout (TIMEOUT_CYCLES>0, counter reaches TIMEOUT_CYCLES with PREADY still 0):
  - PSEL and PENABLE drop to 0.
  - rsp_rdata = 0, rsp_err = 1, rsp_timeout = 1; go to RESP.
- Timeout priority: PREADY=1 in the same cycle the counter would expire counts as normal completion, not timeout.
- RESP: rsp_valid=1, response fields held stable. Leave to IDLE on rsp_ready; rsp_valid drops the next cycle. cmd_ready=0 throughout SETUP/ACCESS/RESP; there is no command buffering.
- Outside a transfer, PADDR/PWRITE/PWDATA hold their last values. PSLVERR and PRDATA are ignored outside ACCESS.
- Latency: with zero wait states, command accept to rsp_valid is 3 cycles (SETUP, ACCESS, RESP). Each wait state adds 1 cycle. Minimum issue interval is 4 cycles with rsp_ready tied high.
- The counter is width $clog2(TIMEOUT_CYCLES+1), clears on entry to SETUP, and never wraps.
- Reset mid-transfer: PSEL/PENABLE/rsp_valid deassert asynchronously; the in-flight command is dropped with no response.

Decomposition:
- Shared package apb_pkg holds:
  - the FSM state encoding (2-bit: IDLE=0, SETUP=1, ACCESS=2, RESP=3);
  - UART register address constants: CTRL=0x0, STATS=0x1, TX_DATA=0x2, RX_DATA=0x3, BAUDIV=0x4;
  - STATS bit indices: TX_BUSY=0, TX_DONE=1, RX_BUSY=2, RX_DONE=3, RX_ERROR=4.
- One sub-module, apb_timeout_cnt, is natural: clear/enable/expire, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write with zero wait states: cmd write addr=0x4 data=0x28B, PREADY=1 in first ACCESS cycle -> PSEL rises 1 cycle after accept, PENABLE 1 cycle later; rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read with 2 wait states: read addr=0x1, PREADY low 2 ACCESS cycles then high with PRDATA=0x0000_000A -> ACCESS lasts 3 cycles, PADDR stable throughout, rsp_rdata=0xA, rsp_err=0.
- Slave error: read addr=0x7, PREADY=1 with PSLVERR=1 -> rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=16, PREADY held 0 -> PSEL/PENABLE drop after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Also PREADY=1 on the expiry cycle -> normal completion.
- Response backpressure: rsp_ready low for 5 cycles with a new cmd_valid pending -> rsp_valid and fields held, cmd_ready=0, no new PSEL until 1 cycle after the rsp handshake.
- Reset during ACCESS: assert PRESETn=0 asynchronously mid-wait -> PSEL/PENABLE/rsp_valid go 0 immediately; after release, cmd_ready=1 and no stale response appears.
